// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous imem, delivers {inst, npc} pairs to IF/ID.
// First instruction 2 cycles after reset release; stall holds the output via a 1-entry skid and suppresses issue.
module if_fetch_unit #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] npc_out,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                req_pending_q, req_pending_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]   skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0]   skid_npc_q, skid_npc_d;

    logic [DATA_W-1:0]   sel_inst;
    logic [ADDR_W-1:0]   sel_npc;
    logic                sel_valid;
    logic                consume;

    // The skid entry always wins: a pending response and a full skid never coexist.
    always_comb begin
        sel_valid = skid_valid_q | req_pending_q;
        sel_inst  = skid_valid_q ? skid_inst_q : imem_rdata;
        sel_npc   = skid_valid_q ? skid_npc_q  : req_addr_q + 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pending_d = req_pending_q;
        req_addr_d    = req_addr_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_npc_d    = skid_npc_q;
        imem_en       = 1'b0;
        imem_addr     = pc_q;
        inst_valid    = 1'b0;
        inst_out      = '0;
        npc_out       = '0;
        consume       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                req_pending_d = 1'b0;
                skid_valid_d  = 1'b0;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Squash whatever is presented or in flight; fetch the target even when stalled.
                    imem_en      = 1'b1;
                    imem_addr    = redirect_pc;
                    skid_valid_d = 1'b0;
                end else begin
                    imem_en    = !stall_in;
                    inst_valid = sel_valid;
                    if (sel_valid) begin
                        inst_out = sel_inst;
                        npc_out  = sel_npc;
                    end
                    consume = sel_valid && !stall_in;
                    if (consume) begin
                        skid_valid_d = 1'b0;
                        if (sel_inst[31:26] == HALT_OPCODE) begin
                            state_d = ST_HALT;
                        end
                    end else if (sel_valid && stall_in && !skid_valid_q) begin
                        skid_valid_d = 1'b1;
                        skid_inst_d  = imem_rdata;
                        skid_npc_d   = req_addr_q + 1'b1;
                    end
                end

                req_pending_d = imem_en;
                if (imem_en) begin
                    req_addr_d = imem_addr;
                    pc_d       = imem_addr + 1'b1;
                end
            end

            ST_HALT: begin
                req_pending_d = 1'b0;
                skid_valid_d  = 1'b0;
            end

            default: begin
                state_d       = ST_BOOT;
                req_pending_d = 1'b0;
                skid_valid_d  = 1'b0;
            end
        endcase
    end

    assign halted = (state_q == ST_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            req_pending_q <= 1'b0;
            req_addr_q    <= '0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= '0;
            skid_npc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pending_q <= req_pending_d;
            req_addr_q    <= req_addr_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_npc_q    <= skid_npc_d;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, drives a synchronous-read instruction memory with 1-cycle read latency, and delivers {instruction, next-PC} pairs to IF/ID at one per cycle when unstalled.
- Handles downstream stall through a 1-entry skid buffer, branch/jump redirect from EX with squash of the in-flight fetch, and stops fetching on a HALT opcode.

Parameters:
ADDR_W, 10, PC / instruction-memory word-address width
DATA_W, 32, instruction width
RESET_PC, 0, first fetch address after reset
HALT_OPCODE, 6'b111111, value of inst[31:26] that halts fetch

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
stall_in  in  1  downstream cannot accept this cycle; hold the current output
redirect_valid  in  1  taken branch/jump; priority over stall_in
redirect_pc  in  ADDR_W  redirect target
imem_en  out  1  read request this cycle
imem_addr  out  ADDR_W  read address, sampled by memory at this edge
imem_rdata  in  DATA_W  data for the request issued the previous cycle
inst_valid  out  1  inst_out/npc_out are a real instruction
inst_out  out  DATA_W  instruction to IF/ID (instIn)
npc_out  out  ADDR_W  address of inst_out + 1 (NPCIn)
halted  out  1  high in HALT state

Behaviour:
- State:
  - FSM: BOOT, RUN, HALT.
  - pc_q: next fetch address.
  - req_pending, req_addr_q: a fetch is in flight; its data is on imem_rdata this cycle.
  - skid_valid, skid_inst, skid_npc: the skid buffer.
- Reset (async, reset=0):
  - state=BOOT, pc_q=RESET_PC, req_pending=0, skid_valid=0.
  - Outputs: imem_en=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, npc_out=0, halted=0.
  - Reset asserted mid-operation aborts everything immediately; the in-flight response is discarded.
- BOOT: one cycle with no fetch (imem_en=0), then RUN unconditionally.
- RUN, normal issue:
  - imem_en = !stall_in, imem_addr = pc_q.
  - On issue: pc_q <= pc_q+1, req_pending <= 1, req_addr_q <= pc_q.
  - With no issue: req_pending <= 0.
- Output selection, RUN:
  - If skid_valid, present the skid contents.
  - Else if req_pending, present imem_rdata with npc = req_addr_q+1.
  - Else inst_valid=0.
  - inst_out and npc_out are forced to 0 whenever inst_valid=0.
- Consumption:
  - The presented instruction is consumed when inst_valid & !stall_in.
  - When stall_in=1 and the response comes from imem_rdata, capture it into the skid buffer (skid_valid <= 1).
  - A consumed skid entry is cleared.
  - Because issue is suppressed while stalled, at most one request is ever in flight and the skid never overflows.
- Latency and throughput:
  - First instruction valid 2 cycles after reset release: BOOT, then issue, then data.
  - Steady state is 1 instruction/cycle with no bubbles.
  - Stall release: skid presented in the release cycle, and the new fetch is issued in that same cycle.
- Redirect (RUN, redirect_valid=1), regardless of stall_in:
  - In the redirect cycle: inst_valid=0; skid_valid <= 0; the in-flight response is dropped.
  - imem_en=1, imem_addr=redirect_pc, pc_q <= redirect_pc+1, req_pending <= 1, req_addr_q <= redirect_pc.
  - Penalty: exactly 1 bubble cycle.
  - Redirect and stall together: the target is still fetched; the next cycle its data goes to the skid if stall_in is still 1.
- HALT:
  - Entered on consumption of an instruction with inst[31:26]==HALT_OPCODE. The HALT instruction itself is delivered.
  - Any request issued in the same cycle is squashed: its response is never presented.
  - In HALT: imem_en=0, inst_valid=0, halted=1. redirect_valid and stall_in are ignored.
  - Only reset leaves HALT.
  - A HALT opcode delivered in a redirect cycle cannot occur, since inst_valid=0 in that cycle.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W; 1023+1 wraps to 0 for pc_q, npc_out and the redirect target +1.

Test Plan:
- Reset release, memory returns word = 0x1000_0000+addr, no stall.
  - imem_en first high in cycle 2, at addr 0.
  - inst_valid from cycle 3 every cycle with inst 0x1000_0000, 0x1000_0001, …; npc_out 1, 2, ….
- stall_in high for 3 cycles while streaming at addr 5.
  - The addr-5 instruction is held in the skid (inst_out stable, npc_out=6) and imem_en=0 throughout.
  - On release: addr 5 consumed once, addr 6 follows the next cycle; no duplicate, no loss.
- redirect_valid with redirect_pc=0x200 while addr 9's data is in flight.
  - Addr 9 is never presented; one cycle with inst_valid=0.
  - Next: inst for 0x200 with npc_out=0x201.
- Redirect asserted with stall_in=1 and skid_valid=1.
  - Skid cleared; the 0x200 data is captured into the skid next cycle.
  - Presented after stall_in drops.
- RESET_PC=1022, sequential fetch.
  - npc_out 1023, 0, 1 across the wrap; imem_addr 1022, 1023, 0.
- HALT opcode (0xFC00_0000) at addr 3.
  - Delivered with npc_out=4; halted=1 the next cycle.
  - The addr-4 response is never presented; imem_en stays 0.
  - Redirect is ignored; asserting reset low returns to BOOT.
